// File: rtl/multi_input_conditioner_if.sv
// Pin-side and control-side signals of the multi-channel input conditioner.
// The master side drives the raw inputs and controls; the slave side is the conditioner.
interface multi_input_conditioner_if #(
    parameter int CH = 4
);
    logic [CH-1:0] in;
    logic [1:0]    mode;
    logic [CH-1:0] clr_tgl;
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic [CH-1:0] tgl;
    logic          any_pulse;

    modport master (
        output in, mode, clr_tgl,
        input  level, pulse, tgl, any_pulse
    );

    modport slave (
        input  in, mode, clr_tgl,
        output level, pulse, tgl, any_pulse
    );
endinterface

// File: rtl/multi_input_conditioner.sv
// N-channel button/switch conditioner: synchroniser, counter debouncer,
// mode-selected edge pulse and latch-on/latch-off toggle per channel.
module multi_input_conditioner #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 3,
    parameter int CNT_W       = 4
) (
    input  logic                    CLK_1hz,
    input  logic                    rst,
    multi_input_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [CNT_W-1:0]       cnt_q  [CH];
    logic [CH-1:0]          level_q;
    logic [CH-1:0]          pulse_q;
    logic [CH-1:0]          tgl_q;

    logic [CH-1:0]          s;
    logic [CH-1:0]          accept;
    logic [CH-1:0]          pulse_d;

    // Accept fires on the last of DEB_CNT differing samples; mode decides which directions pulse
    always_comb begin
        s       = '0;
        accept  = '0;
        pulse_d = '0;
        for (int i = 0; i < CH; i++) begin
            s[i]      = sync_q[i][SYNC_STAGES-1];
            accept[i] = (s[i] != level_q[i]) && (cnt_q[i] == CNT_MAX);
            case (bus.mode)
                2'b00:   pulse_d[i] = accept[i] &  s[i];
                2'b01:   pulse_d[i] = accept[i] & ~s[i];
                2'b10:   pulse_d[i] = accept[i];
                default: pulse_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK_1hz) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level_q <= '0;
            pulse_q <= '0;
            tgl_q   <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.in[i]};
                if (s[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    level_q[i] <= s[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
                // A clear wins over a flip arriving on the same edge
                if (bus.clr_tgl[i]) begin
                    tgl_q[i] <= 1'b0;
                end else if (pulse_d[i]) begin
                    tgl_q[i] <= ~tgl_q[i];
                end
            end
            pulse_q <= pulse_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.pulse     = pulse_q;
    assign bus.tgl       = tgl_q;
    assign bus.any_pulse = |pulse_q;

endmodule

// File: doc/multi_input_conditioner.md
Name: multi_input_conditioner

Overview:
- Parametrised N-channel push-button/switch conditioner.
- Each channel runs: raw async input -> SYNC_STAGES-flop synchroniser -> counter debouncer -> configurable edge-pulse generator -> toggle (latch-on/latch-off) register.
- Sits between board pins and the control FSMs; all logic runs on the divided clock CLK_1hz.

Parameters:
- CH, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser depth per channel (>=2)
- DEB_CNT, 3, consecutive differing samples required to accept a new level (1..2^CNT_W-1)
- CNT_W, 4, debounce counter width

Ports:
- CLK_1hz  in  1  divided system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in  in  CH  raw asynchronous button/switch inputs
- mode  in  2  edge select: 00 rising, 01 falling, 10 both, 11 pulses disabled
- clr_tgl  in  CH  per-channel synchronous toggle clear
- level  out  CH  debounced level per channel
- pulse  out  CH  one-cycle edge pulse per channel
- tgl  out  CH  toggle state per channel
- any_pulse  out  1  OR-reduction of pulse

Behaviour:
- Reset: rst=0 at a CLK_1hz edge clears all sync flops, counters, level, pulse and tgl to 0, so any_pulse=0. Reset overrides all other inputs, including mid-debounce; the counter restarts from 0.
- Synchroniser: shift chain per channel. The last stage is s[i]. A change on in[i] reaches s[i] SYNC_STAGES edges after it is first sampled.
- Debouncer, per channel with counter cnt[i] (CNT_W bits), evaluated each edge:
  - s==level: cnt<=0.
  - s!=level and cnt==DEB_CNT-1: level<=s, cnt<=0, edge event generated.
  - s!=level otherwise: cnt<=cnt+1.
  - Result: a new level is accepted after exactly DEB_CNT consecutive differing samples. Total latency from first sampling edge to level change is SYNC_STAGES+DEB_CNT edges.
  - A glitch shorter than DEB_CNT samples at s resets cnt and produces no level change and no pulse.
  - DEB_CNT=1: level follows s with a one-edge delay.
- Pulse: registered, asserted high for exactly one cycle on the same edge that level updates, when the event qualifies under mode:
  - 00: 0->1 only.
  - 01: 1->0 only.
  - 10: both directions.
  - 11: never.
  - Pulse deasserts on the next edge unconditionally.
  - Back-to-back qualifying events are impossible closer than DEB_CNT edges.
- Mode: sampled on the same edge as the event; a change takes effect for events at that edge onward. There is no retroactive pulse for past events.
- Toggle: on the edge pulse[i] is set, tgl[i]<=~tgl[i]. Priority per channel:
  1. reset
  2. clr_tgl[i]=1 (tgl<=0, even if an event occurs the same edge)
  3. flip
- mode=11 freezes tgl (still clearable); level continues to track.
- Channels are fully independent; simultaneous events on several channels each produce their own pulse and flip.
- any_pulse is combinational OR of the pulse register outputs (no extra latency).
- Counter never exceeds DEB_CNT-1; no wrap-around.

Test Plan:
- Reset hold: rst=0 for 2 edges with in=4'hF -> level, pulse, tgl all 0. After release (defaults), level=4'hF on edge 5 with pulse=4'hF for one cycle and tgl=4'hF.
- Debounce latency: defaults, mode=00, in[0] 0->1 held -> level[0] and pulse[0] rise exactly 5 edges after first sampling edge. pulse[0] is 1 for one cycle; tgl[0] flips to 1.
- Glitch reject: in[1] high for 2 sampled cycles then low, DEB_CNT=3 -> level[1], pulse[1], tgl[1] remain 0 throughout.
- Mode sweep: one press/release (hold 6 cycles each) per mode:
  - 00: one pulse on the press.
  - 01: one pulse on the release.
  - 10: two pulses.
  - 11: zero pulses and tgl unchanged; level still follows.
- Clear priority: clr_tgl[2]=1 on the same edge as a qualifying event on ch2 with tgl[2]=1 -> tgl[2]=0, pulse[2]=1. Simultaneous events on ch0 and ch3 -> pulse=4'b1001, any_pulse=1 for one cycle.
- Reset mid-debounce: rst=0 while cnt[0]=2 -> next edge cnt=0, level=0. After release, full SYNC_STAGES+DEB_CNT latency is required again.
